// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH flip-flop channels, each run-time programmable
// as D, T, JK or SR, with enable, sticky SR-conflict and change flags.
module ff_bank_multimode #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_we,
  input  logic [2*WIDTH-1:0] mode_wdata,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qn,
  output logic [2*WIDTH-1:0] mode_q,
  output logic [WIDTH-1:0]   sr_err,
  output logic [WIDTH-1:0]   chg
);

  localparam logic [1:0] M_D  = 2'b00;
  localparam logic [1:0] M_T  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_SR = 2'b11;

  logic [WIDTH-1:0]   st_q, st_d;
  logic [WIDTH-1:0]   stn_q, stn_d;
  logic [2*WIDTH-1:0] mode_reg_q, mode_reg_d;
  logic [WIDTH-1:0]   err_q, err_d;
  logic [WIDTH-1:0]   chg_q, chg_d;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   cfl;

  always_comb begin
    nxt = st_q;
    cfl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode_reg_q[2*i +: 2])
        M_D:  nxt[i] = a[i];
        M_T:  nxt[i] = st_q[i] ^ a[i];
        M_JK: begin
          unique case ({a[i], b[i]})
            2'b00:   nxt[i] = st_q[i];
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            default: nxt[i] = ~st_q[i];
          endcase
        end
        default: begin
          unique case ({a[i], b[i]})
            2'b01:   nxt[i] = 1'b0;
            2'b10:   nxt[i] = 1'b1;
            default: nxt[i] = st_q[i];
          endcase
          cfl[i] = a[i] & b[i];
        end
      endcase
    end
  end

  // a conflict raised this cycle wins over a simultaneous clear
  always_comb begin
    st_d       = en ? nxt : st_q;
    stn_d      = ~st_d;
    chg_d      = en ? (nxt ^ st_q) : '0;
    err_d      = (en ? cfl : '0) | (err_clr ? '0 : err_q);
    mode_reg_d = mode_we ? mode_wdata : mode_reg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= RST_VAL;
      stn_q      <= ~RST_VAL;
      mode_reg_q <= '0;
      err_q      <= '0;
      chg_q      <= '0;
    end else begin
      st_q       <= st_d;
      stn_q      <= stn_d;
      mode_reg_q <= mode_reg_d;
      err_q      <= err_d;
      chg_q      <= chg_d;
    end
  end

  assign q      = st_q;
  assign qn     = stn_q;
  assign mode_q = mode_reg_q;
  assign sr_err = err_q;
  assign chg    = chg_q;

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Directed bench for ff_bank_multimode with a behavioural model
// feeding an expected-value queue checked after every edge.
module tb_ff_bank_multimode;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_we;
  logic [15:0] mode_wdata;
  logic        en;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        err_clr;
  logic [7:0]  q;
  logic [7:0]  qn;
  logic [15:0] mode_q;
  logic [7:0]  sr_err;
  logic [7:0]  chg;

  ff_bank_multimode #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_we    (mode_we),
    .mode_wdata (mode_wdata),
    .en         (en),
    .a          (a),
    .b          (b),
    .err_clr    (err_clr),
    .q          (q),
    .qn         (qn),
    .mode_q     (mode_q),
    .sr_err     (sr_err),
    .chg        (chg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  qn;
    logic [15:0] mode;
    logic [7:0]  err;
    logic [7:0]  chg;
  } exp_t;

  exp_t sb[$];

  int nchecks = 0;
  int nerr    = 0;

  logic [7:0]  m_q    = 8'h00;
  logic [15:0] m_mode = 16'h0000;
  logic [7:0]  m_err  = 8'h00;
  logic [7:0]  m_chg  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: evaluates each channel from its own mode.
  task automatic model(input logic r, input logic we,
                       input logic [15:0] wd, input logic e,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic ec);
    logic [7:0] nq;
    logic [7:0] cf;
    logic [1:0] md;
    exp_t x;
    if (r) begin
      m_q = 8'h00; m_mode = 16'h0; m_err = 8'h00; m_chg = 8'h00;
    end else begin
      nq = m_q;
      cf = 8'h00;
      for (int i = 0; i < 8; i++) begin
        md = m_mode[2*i +: 2];
        if (md == 2'd0) nq[i] = aa[i];
        else if (md == 2'd1) nq[i] = aa[i] ? ~m_q[i] : m_q[i];
        else if (aa[i] && !bb[i]) nq[i] = 1'b1;
        else if (!aa[i] && bb[i]) nq[i] = 1'b0;
        else if (aa[i] && bb[i]) begin
          if (md == 2'd2) nq[i] = ~m_q[i];
          else cf[i] = e;
        end
      end
      m_chg = e ? (nq ^ m_q) : 8'h00;
      m_err = cf | (ec ? 8'h00 : m_err);
      if (e) m_q = nq;
      if (we) m_mode = wd;
    end
    x.q = m_q; x.qn = ~m_q; x.mode = m_mode;
    x.err = m_err; x.chg = m_chg;
    sb.push_back(x);
  endtask

  task automatic step(input logic r, input logic we,
                      input logic [15:0] wd, input logic e,
                      input logic [7:0] aa, input logic [7:0] bb,
                      input logic ec);
    exp_t x;
    rst = r; mode_we = we; mode_wdata = wd;
    en = e; a = aa; b = bb; err_clr = ec;
    model(r, we, wd, e, aa, bb, ec);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nchecks++;
      nerr++;
      $display("FAIL sb_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      chk("q", {24'h0, q}, {24'h0, x.q});
      chk("qn", {24'h0, qn}, {24'h0, x.qn});
      chk("mode_q", {16'h0, mode_q}, {16'h0, x.mode});
      chk("sr_err", {24'h0, sr_err}, {24'h0, x.err});
      chk("chg", {24'h0, chg}, {24'h0, x.chg});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  hold_q;
    logic [15:0] mset [4];
    mset[0] = 16'h0000; mset[1] = 16'h5555;
    mset[2] = 16'hAAAA; mset[3] = 16'hFFFF;

    // reset for two edges, with other controls active
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 8'hFF, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 8'hFF, 8'hFF, 1'b0);
    chk("rst_q", {24'h0, q}, 32'h00);
    chk("rst_qn", {24'h0, qn}, 32'hFF);
    chk("rst_mode", {16'h0, mode_q}, 32'h0);

    // D mode
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'hA5, 8'h00, 1'b0);
    chk("d_q", {24'h0, q}, 32'hA5);
    chk("d_qn", {24'h0, qn}, 32'h5A);
    chk("d_chg", {24'h0, chg}, 32'hA5);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, 8'h00, 1'b0);

    // mode write uses old mode on the same edge
    step(1'b0, 1'b1, 16'h5555, 1'b1, 8'hFF, 8'h00, 1'b0);
    chk("mw_old", {24'h0, q}, 32'hFF);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'hFF, 8'h00, 1'b0);
    chk("mw_new", {24'h0, q}, 32'h00);

    // JK truth
    step(1'b0, 1'b1, 16'hAAAA, 1'b1, 8'h0F, 8'h00, 1'b0);
    chk("t_set", {24'h0, q}, 32'h0F);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'hF0, 8'hFF, 1'b0);
    chk("jk_q", {24'h0, q}, 32'hF0);

    // SR truth
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 8'h0F, 8'hF0, 1'b0);
    chk("jk_ld", {24'h0, q}, 32'h0F);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'hF0, 8'hFF, 1'b0);
    chk("sr_q", {24'h0, q}, 32'h00);
    chk("sr_err", {24'h0, sr_err}, 32'hF0);

    // sticky error priority
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h01, 8'h01, 1'b1);
    chk("err_prio", {24'h0, sr_err}, 32'h01);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h00, 8'h00, 1'b1);
    chk("err_clr", {24'h0, sr_err}, 32'h00);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h02, 8'h02, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    chk("err_en0", {24'h0, sr_err}, 32'h02);

    // enable low holds in every mode
    for (int m = 0; m < 4; m++) begin
      step(1'b0, 1'b1, mset[m], 1'b0, 8'hFF, 8'hFF, 1'b0);
      hold_q = m_q;
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b0, 16'h0, 1'b0, 8'($urandom),
             8'($urandom), 1'b0);
        chk("hold_q", {24'h0, q}, {24'h0, hold_q});
        chk("hold_chg", {24'h0, chg}, 32'h0);
      end
    end

    // mixed modes: ch0 D, ch1 T, ch2 JK, ch3 SR
    step(1'b0, 1'b1, 16'h00E4, 1'b1, 8'h00, 8'hFF, 1'b1);
    chk("mix_clr", {24'h0, q}, 32'h00);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h0F, 8'h0F, 1'b0);
    chk("mix_q", {24'h0, q}, 32'h07);
    chk("mix_err", {24'h0, sr_err}, 32'h08);

    // reset mid-operation while toggling
    step(1'b0, 1'b1, 16'h5555, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 16'h0, 1'b1, 8'hFF, 8'h00, 1'b0);
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 8'hFF, 8'hFF, 1'b1);
    chk("mid_rst_q", {24'h0, q}, 32'h00);
    chk("mid_rst_mode", {16'h0, mode_q}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'h3C, 8'h00, 1'b0);
    chk("post_rst", {24'h0, q}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
